// File: rtl/delta_controller_output_writer_if.sv
// Output-buffer read port and DRAM write port of the output writer.
// The writer is the master: it selects a PU buffer, pulses the clear line
// and issues DRAM writes. The slave side holds the buffers and the memory.
interface delta_controller_output_writer_if #(
  parameter int OUT_BIN_LEN    = 24,
  parameter int PU_NUM         = 4,
  parameter int OUTPUT_CHANNEL = 4
);

  logic signed [PU_NUM-1:0][OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] OB_read_data;
  logic [PU_NUM-1:0] OB_r_enable;
  logic              OB_clear;
  logic              DRAM_Write;
  logic [31:0]       DRAM_Address;
  logic [31:0]       DRAM_WriteData;
  logic              DRAM_WriteDone;

  modport master (
    input  OB_read_data,
    input  DRAM_WriteDone,
    output OB_r_enable,
    output OB_clear,
    output DRAM_Write,
    output DRAM_Address,
    output DRAM_WriteData
  );

  modport slave (
    output OB_read_data,
    output DRAM_WriteDone,
    input  OB_r_enable,
    input  OB_clear,
    input  DRAM_Write,
    input  DRAM_Address,
    input  DRAM_WriteData
  );

endinterface

// File: rtl/delta_controller_output_writer.sv
// Output writer: drains the per-PU output buffers once a tile has finished
// accumulating. Each accumulator goes through optional ReLU and signed
// saturation, two results are packed per 32-bit word and written to DRAM
// one word at a time, and finally the buffers are cleared for the next tile.
module delta_controller_output_writer #(
  parameter int BIN_LEN        = 16,
  parameter int OUT_BIN_LEN    = 24,
  parameter int PU_NUM         = 4,
  parameter int OUTPUT_CHANNEL = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] output_start_address,
  input  logic        relu_en,
  output logic        finished,
  delta_controller_output_writer_if.master bus
);

  localparam int WORD_NUM = OUTPUT_CHANNEL / 2;
  localparam int PU_W     = (PU_NUM > 1) ? $clog2(PU_NUM) : 1;
  localparam int WORD_W   = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

  localparam logic signed [OUT_BIN_LEN-1:0] SAT_MAX =
    {{(OUT_BIN_LEN-BIN_LEN+1){1'b0}}, {(BIN_LEN-1){1'b1}}};
  localparam logic signed [OUT_BIN_LEN-1:0] SAT_MIN =
    {{(OUT_BIN_LEN-BIN_LEN+1){1'b1}}, {(BIN_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    READ_PU,
    WRITE,
    NEXT,
    CLEAR,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PU_W-1:0]   puIdx_q, puIdx_d;
  logic [WORD_W-1:0] wordIdx_q, wordIdx_d;
  logic [31:0]       addr_q, addr_d;
  logic              relu_q, relu_d;
  logic [OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] chan_q, chan_d;

  logic              lastWord;
  logic              lastPu;

  logic [PU_NUM-1:0] rEnable;
  logic              obClear;
  logic              dramWrite;
  logic [31:0]       dramAddress;
  logic [31:0]       dramWriteData;
  logic              finishedPulse;

  // ReLU first, then clamp into the signed BIN_LEN range.
  function automatic logic [BIN_LEN-1:0] postProc(
    input logic signed [OUT_BIN_LEN-1:0] x,
    input logic                          relu
  );
    logic [BIN_LEN-1:0] result;
    if (relu && (x < 0)) begin
      result = '0;
    end else if (x > SAT_MAX) begin
      result = {1'b0, {(BIN_LEN-1){1'b1}}};
    end else if (x < SAT_MIN) begin
      result = {1'b1, {(BIN_LEN-1){1'b0}}};
    end else begin
      result = x[BIN_LEN-1:0];
    end
    return result;
  endfunction

  assign lastWord = (wordIdx_q == WORD_W'(WORD_NUM - 1));
  assign lastPu   = (puIdx_q == PU_W'(PU_NUM - 1));

  // State register; reset aborts any drain straight back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: one word per WRITE/NEXT pair, one READ_PU per PU.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ_PU;
        end
      end
      READ_PU: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.DRAM_WriteDone) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (!lastWord) begin
          state_d = WRITE;
        end else if (!lastPu) begin
          state_d = READ_PU;
        end else begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: latch the job on start, capture a PU, step counters.
  always_comb begin
    puIdx_d   = puIdx_q;
    wordIdx_d = wordIdx_q;
    addr_d    = addr_q;
    relu_d    = relu_q;
    chan_d    = chan_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = output_start_address;
          relu_d    = relu_en;
          puIdx_d   = '0;
          wordIdx_d = '0;
        end
      end
      READ_PU: begin
        for (int p = 0; p < PU_NUM; p++) begin
          if (puIdx_q == PU_W'(p)) begin
            chan_d = bus.OB_read_data[p];
          end
        end
      end
      WRITE: begin
        if (bus.DRAM_WriteDone) begin
          addr_d = addr_q + 32'd4;
        end
      end
      NEXT: begin
        if (!lastWord) begin
          wordIdx_d = wordIdx_q + WORD_W'(1);
        end else if (!lastPu) begin
          wordIdx_d = '0;
          puIdx_d   = puIdx_q + PU_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      puIdx_q   <= '0;
      wordIdx_q <= '0;
      addr_q    <= '0;
      relu_q    <= 1'b0;
      chan_q    <= '0;
    end else begin
      puIdx_q   <= puIdx_d;
      wordIdx_q <= wordIdx_d;
      addr_q    <= addr_d;
      relu_q    <= relu_d;
      chan_q    <= chan_d;
    end
  end

  // Outputs decode only from state and registers, never from DRAM_WriteDone.
  always_comb begin
    rEnable       = '0;
    obClear       = 1'b0;
    dramWrite     = 1'b0;
    dramAddress   = '0;
    dramWriteData = '0;
    finishedPulse = 1'b0;
    case (state_q)
      READ_PU: begin
        for (int p = 0; p < PU_NUM; p++) begin
          rEnable[p] = (puIdx_q == PU_W'(p));
        end
      end
      WRITE: begin
        dramWrite   = 1'b1;
        dramAddress = addr_q;
        for (int w = 0; w < WORD_NUM; w++) begin
          if (wordIdx_q == WORD_W'(w)) begin
            dramWriteData = {postProc(chan_q[2*w+1], relu_q),
                             postProc(chan_q[2*w], relu_q)};
          end
        end
      end
      CLEAR: begin
        obClear = 1'b1;
      end
      DONE: begin
        finishedPulse = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.OB_r_enable    = rEnable;
  assign bus.OB_clear       = obClear;
  assign bus.DRAM_Write     = dramWrite;
  assign bus.DRAM_Address   = dramAddress;
  assign bus.DRAM_WriteData = dramWriteData;
  assign finished           = finishedPulse;

endmodule
